vc_ibuf: RTL and testbench

- Per-virtual-channel input flit buffer; sits directly upstream of the per-VC routing/allocation controller.
- Accepts flits from the input link, stores them in a circular FIFO, and presents the oldest flit as the controller's buffered-data input.
- Pops a flit when the controller's flit is transferred through the switch.
- Reports space availability upstream and flags protocol violations.

---
 rtl/vc_ibuf_pkg.sv | 27 ++
 rtl/vc_ibuf_if.sv | 29 ++
 rtl/vc_ibuf_fifo_ram.sv | 24 ++
 rtl/vc_ibuf.sv | 117 +++++++++++
 tb/tb_vc_ibuf.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_ibuf_pkg.sv
// Shared constants for the per-VC input flit buffer.
// Flit type lives in the two MSBs of a flit. A HEADTAIL (single-flit packet)
// is a HEAD whose header bit at DATAW-2 is set; that bit is meaningless for
// the other types.
package vc_ibuf_pkg;

    // Default geometry: 36-bit flits, 4 entries, 2-bit pointers
    localparam int DATAW_DEF = 35;
    localparam int DEPTH_DEF = 4;
    localparam int PTRW_DEF  = 1;

    // Field positions, expressed as offsets down from the flit MSB (DATAW)
    localparam int TYPE_MSB_OFS = 0;
    localparam int TYPE_LSB_OFS = 1;
    localparam int HT_OFS       = 2;

    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_HEAD = 2'b01,
        FT_BODY = 2'b10,
        FT_TAIL = 2'b11
    } flit_type_e;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/vc_ibuf_if.sv
// Link/controller-facing signals of the VC input buffer.
// Handshake: the upstream link pushes a flit in any cycle with ivalid=1; it
// should only do so when ordy was 1, otherwise the flit is dropped and err set.
// The buffer offers the oldest flit on bdata with bvalid=1; the controller
// consumes it by raising deq in that cycle. deq with bvalid=0 is an error.
interface vc_ibuf_if #(
    parameter int DATAW = 35,
    parameter int PTRW  = 1
);
    logic [DATAW:0]  idata;
    logic            ivalid;
    logic            ordy;
    logic [DATAW:0]  bdata;
    logic            bvalid;
    logic            deq;
    logic [PTRW+1:0] count;
    logic            err;
    logic            in_pkt;   // debug view of the packet-framing state

    modport master (
        output idata, ivalid, deq,
        input  ordy, bdata, bvalid, count, err, in_pkt
    );

    modport slave (
        input  idata, ivalid, deq,
        output ordy, bdata, bvalid, count, err, in_pkt
    );
endinterface

// File: rtl/vc_ibuf_fifo_ram.sv
// DEPTH x (DATAW+1) register array: one synchronous write port, async read.
module vc_ibuf_fifo_ram #(
    parameter int DATAW = 35,
    parameter int DEPTH = 4,
    parameter int PTRW  = 1
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [PTRW:0]  i_waddr,
    input  logic [DATAW:0] i_wdata,
    input  logic [PTRW:0]  i_raddr,
    output logic [DATAW:0] o_rdata
);
    logic [DATAW:0] r_mem [DEPTH];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/vc_ibuf.sv
// Per-VC input flit buffer: circular FIFO with count-based full/empty,
// packet-framing check on accepted flits and a sticky error flag.
module vc_ibuf
    import vc_ibuf_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTRW  = PTRW_DEF
) (
    input logic       clk,
    input logic       rst,
    vc_ibuf_if.slave  bus
);
    localparam int L_TMSB = DATAW - TYPE_MSB_OFS;
    localparam int L_TLSB = DATAW - TYPE_LSB_OFS;
    localparam int L_HT   = DATAW - HT_OFS;
    localparam logic [PTRW+1:0] L_FULL = (PTRW+2)'(DEPTH);
    localparam logic [PTRW+1:0] L_ONE  = (PTRW+2)'(1);

    logic [PTRW:0]   r_wptr;
    logic [PTRW:0]   r_rptr;
    logic [PTRW+1:0] r_count;
    logic            r_err;
    logic            r_in_pkt;

    flit_type_e      w_type;
    logic            w_ht;
    logic            w_full;
    logic            w_empty;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_frame_err;
    logic            w_in_pkt_nxt;
    logic            w_err_set;
    logic [DATAW:0]  w_rdata;

    assign w_type     = flit_type_e'(bus.idata[L_TMSB:L_TLSB]);
    assign w_ht       = bus.idata[L_HT];
    assign w_full     = (r_count == L_FULL);
    assign w_empty    = (r_count == '0);
    // NONE flits are not traffic: never stored, never an error
    assign w_push_req = bus.ivalid && (w_type != FT_NONE);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = bus.deq && !w_empty;

    // Framing rules for the incoming flit against the current packet state
    always_comb begin
        w_frame_err  = DISABLE;
        w_in_pkt_nxt = r_in_pkt;
        case (w_type)
            FT_HEAD: begin
                w_frame_err  = r_in_pkt;
                w_in_pkt_nxt = w_ht ? DISABLE : ENABLE;
            end
            FT_BODY: begin
                w_frame_err  = !r_in_pkt;
            end
            FT_TAIL: begin
                w_frame_err  = !r_in_pkt;
                w_in_pkt_nxt = DISABLE;
            end
            default: ;
        endcase
    end

    // Dropped push (full), pop while empty, or bad framing on a stored flit
    assign w_err_set = (w_push_req && w_full) || (bus.deq && w_empty) ||
                       (w_push && w_frame_err);

    // Pointers, occupancy, framing state and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_err    <= DISABLE;
            r_in_pkt <= DISABLE;
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + 1'b1;
                r_in_pkt <= w_in_pkt_nxt;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= ENABLE;
            end
        end
    end

    vc_ibuf_fifo_ram #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (bus.idata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign bus.bdata  = w_empty ? '0 : w_rdata;
    assign bus.bvalid = !w_empty;
    assign bus.ordy   = !w_full;
    assign bus.count  = r_count;
    assign bus.err    = r_err;
    assign bus.in_pkt = r_in_pkt;
endmodule

// File: tb/tb_vc_ibuf.sv
// Self-checking bench for vc_ibuf against a queue-based packet-buffer model.
module tb_vc_ibuf;
    localparam int DATAW = 35;
    localparam int DEPTH = 4;
    localparam int PTRW  = 1;
    localparam int VW    = DATAW + 1 + 7;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vc_ibuf_if #(.DATAW(DATAW), .PTRW(PTRW)) bus_if ();

    vc_ibuf #(.DATAW(DATAW), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus sticky error and packet state
    logic [DATAW:0] exp_q[$];
    logic           m_err;
    logic           m_in_pkt;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DATAW:0] mk(input logic [1:0] t, input logic [DATAW-2:0] p);
        return {t, p};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_err    = 1'b0;
        m_in_pkt = 1'b0;
    endfunction

    function automatic void model_update(input logic [DATAW:0] d, input logic iv, input logic dq);
        int sz;
        logic [1:0] t;
        logic ht;
        sz = exp_q.size();
        t  = d[DATAW:DATAW-1];
        ht = d[DATAW-2];
        if (dq) begin
            if (sz > 0) void'(exp_q.pop_front());
            else m_err = 1'b1;
        end
        if (iv && t != T_NONE) begin
            if (sz == DEPTH) begin
                m_err = 1'b1;
            end else begin
                exp_q.push_back(d);
                if (t == T_HEAD && m_in_pkt) m_err = 1'b1;
                if ((t == T_BODY || t == T_TAIL) && !m_in_pkt) m_err = 1'b1;
                if (t == T_HEAD) m_in_pkt = !ht;
                if (t == T_TAIL) m_in_pkt = 1'b0;
            end
        end
    endfunction

    // {bvalid, ordy, count, err, in_pkt, bdata}
    function automatic logic [VW-1:0] exp_vec();
        logic [DATAW:0] head;
        int sz;
        sz   = exp_q.size();
        head = (sz > 0) ? exp_q[0] : '0;
        return {sz != 0, sz < DEPTH, 3'(sz), m_err, m_in_pkt, head};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus_if.bvalid, bus_if.ordy, bus_if.count, bus_if.err, bus_if.in_pkt, bus_if.bdata};
    endfunction

    // Driver: apply inputs, clock once, advance model, settle past the edge
    task automatic cycle(input logic [DATAW:0] d, input logic iv, input logic dq);
        bus_if.idata  = d;
        bus_if.ivalid = iv;
        bus_if.deq    = dq;
        @(posedge clk);
        if (rst) model_reset();
        else model_update(d, iv, dq);
        #1;
        bus_if.ivalid = 1'b0;
        bus_if.deq    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle('0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle('0, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 36'd0}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs_vec(),
                         {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 36'd0});
            end
        end
    endtask

    task automatic test_in_order();
        logic [DATAW:0] f [3];
        int exp_cnt [6];
        exp_cnt = '{1, 2, 3, 2, 1, 0};
        f[0] = mk(T_HEAD, 34'h1_0001);
        f[1] = mk(T_BODY, 34'h0_0002);
        f[2] = mk(T_TAIL, 34'h0_0003);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(f[i], 1'b1, 1'b0);
            else cycle('0, 1'b0, 1'b1);
            n_checks++;
            if (bus_if.count !== 3'(exp_cnt[i]) || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL in_order[%0d]: got count %0d vec %h expected count %0d vec %h",
                         i, bus_if.count, obs_vec(), exp_cnt[i], exp_vec());
            end
        end
        n_checks++;
        if (bus_if.err !== 1'b0) begin
            n_fail++;
            $display("FAIL in_order_err: got %b expected 0", bus_if.err);
        end
    endtask

    task automatic test_full();
        do_reset();
        cycle(mk(T_HEAD, 34'h10), 1'b1, 1'b0);
        for (int i = 1; i < DEPTH; i++) cycle(mk(T_BODY, 34'(i + 16)), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.count !== 3'd4 || bus_if.ordy !== 1'b0 || bus_if.err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count %0d ordy %b err %b expected 4 0 0",
                     bus_if.count, bus_if.ordy, bus_if.err);
        end
        cycle(mk(T_BODY, 34'h3_dead), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.count !== 3'd4 || bus_if.err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_overflow: got count %0d err %b expected 4 1", bus_if.count, bus_if.err);
        end
        // Push at full alongside a pop: flit still dropped
        cycle(mk(T_BODY, 34'h3_beef), 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            cycle('0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(mk(T_HEAD, 34'h100), 1'b1, 1'b0);
        cycle(mk(T_BODY, 34'h101), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(mk(T_BODY, 34'($urandom)), 1'b1, 1'b1);
            n_checks++;
            if (bus_if.count !== 3'd2 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_framing();
        do_reset();
        cycle(mk(T_BODY, 34'h55), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.err !== 1'b1 || bus_if.count !== 3'd1 || bus_if.bdata !== mk(T_BODY, 34'h55)) begin
            n_fail++;
            $display("FAIL orphan_body: got err %b count %0d bdata %h expected 1 1 %h",
                     bus_if.err, bus_if.count, bus_if.bdata, mk(T_BODY, 34'h55));
        end
        do_reset();
        cycle(mk(T_HEAD, 34'h1), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.err !== 1'b0) begin
            n_fail++;
            $display("FAIL first_head: got err %b expected 0", bus_if.err);
        end
        cycle(mk(T_HEAD, 34'h2), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.err !== 1'b1 || bus_if.count !== 3'd2) begin
            n_fail++;
            $display("FAIL head_head: got err %b count %0d expected 1 2", bus_if.err, bus_if.count);
        end
        // HEADTAIL and NONE flits are legal and leave no open packet
        do_reset();
        cycle(mk(T_HEAD, 34'h2_0000_0007), 1'b1, 1'b0);
        cycle(mk(T_NONE, 34'h9), 1'b1, 1'b0);
        cycle(mk(T_HEAD, 34'h2_0000_0008), 1'b1, 1'b0);
        n_checks++;
        if (bus_if.err !== 1'b0 || bus_if.count !== 3'd2 || bus_if.in_pkt !== 1'b0) begin
            n_fail++;
            $display("FAIL headtail_none: got err %b count %0d in_pkt %b expected 0 2 0",
                     bus_if.err, bus_if.count, bus_if.in_pkt);
        end
        // Pop from empty is an error
        do_reset();
        cycle('0, 1'b0, 1'b1);
        n_checks++;
        if (bus_if.err !== 1'b1 || bus_if.count !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_pop: got err %b count %0d expected 1 0", bus_if.err, bus_if.count);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cycle(mk(T_HEAD, 34'h7), 1'b1, 1'b0);
        cycle(mk(T_BODY, 34'h8), 1'b1, 1'b0);
        cycle(mk(T_HEAD, 34'h9), 1'b1, 1'b0);
        rst = 1'b1;
        cycle(mk(T_BODY, 34'ha), 1'b1, 1'b1);
        rst = 1'b0;
        n_checks++;
        if (obs_vec() !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 36'd0}) begin
            n_fail++;
            $display("FAIL reset_midflight: got %h expected %h", obs_vec(),
                     {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 36'd0});
        end
    endtask

    task automatic test_random();
        logic [1:0] t;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) do_reset();
            t = 2'($urandom_range(0, 3));
            cycle(mk(t, 34'($urandom)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus_if.idata  = '0;
        bus_if.ivalid = 1'b0;
        bus_if.deq    = 1'b0;
        model_reset();
        test_reset();
        test_in_order();
        test_full();
        test_back_to_back();
        test_framing();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
